// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 convolution/maxpool sequencer.
// Frame configuration checks live here so that every user agrees on them.
package conv_pkg;

    localparam int unsigned PIX_W  = 8;
    localparam int unsigned COEF_W = 8;
    localparam int unsigned BIAS_W = 32;
    localparam int unsigned RES_W  = 20;
    localparam int unsigned DIM_W  = 8;
    localparam int unsigned N_TAPS = 9;

    localparam logic [1:0] OP_CONV3X3    = 2'd0;
    localparam logic [1:0] OP_MAXPOOL2X2 = 2'd1;
    localparam logic [1:0] OP_TRANSCONV  = 2'd2;

    localparam logic [3:0] W_ADDR_BIAS = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    typedef struct packed {
        logic [DIM_W-1:0] width;
        logic [DIM_W-1:0] height;
        logic [1:0]       op;
        logic             relu;
    } frame_cfg_t;

    typedef struct packed {
        logic             valid;
        logic [DIM_W-1:0] row;
        logic [DIM_W-1:0] col;
    } out_tag_t;

    // True when the frame cannot be run by the datapath as configured.
    function automatic logic cfg_invalid(input frame_cfg_t cfg,
                                         input logic [DIM_W-1:0] max_w,
                                         input logic [DIM_W-1:0] max_h);
        logic bad;
        bad = (cfg.width > max_w) || (cfg.height > max_h);
        case (cfg.op)
            OP_CONV3X3:
                bad = bad || (cfg.width < DIM_W'(3)) || (cfg.height < DIM_W'(3));
            OP_MAXPOOL2X2:
                bad = bad || (cfg.width == '0) || (cfg.height == '0)
                          || cfg.width[0] || cfg.height[0];
            default:
                bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/conv3x3_weight_bank.sv
// Nine 8-bit weights plus a 32-bit bias, single write port, parallel read-out.
// Weight w(n+1) sits in bits [8n+7:8n] of the flattened weight bus.
module conv3x3_weight_bank
    import conv_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic [3:0]                 addr,
    input  logic [BIAS_W-1:0]          data,
    output logic [N_TAPS*COEF_W-1:0]   weights,
    output logic [BIAS_W-1:0]          bias
);

    logic [N_TAPS-1:0][COEF_W-1:0] w_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_q  <= '0;
            bias <= '0;
        end else if (we) begin
            if (addr == W_ADDR_BIAS) begin
                bias <= data;
            end
            for (int i = 0; i < int'(N_TAPS); i++) begin
                if (addr == 4'(i)) begin
                    w_q[i] <= data[COEF_W-1:0];
                end
            end
        end
    end

    assign weights = w_q;

endmodule

// File: rtl/conv3x3_sequencer.sv
// Frame controller for one convolutor3x3: owns the weight bank, streams a frame,
// drives padding/op controls and forwards only geometrically valid results.
module conv3x3_sequencer
    import conv_pkg::*;
#(
    parameter int unsigned MAX_WIDTH  = 128,
    parameter int unsigned MAX_HEIGHT = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  cfg_width,
    input  logic [7:0]  cfg_height,
    input  logic [1:0]  cfg_op,
    input  logic        cfg_relu,
    input  logic        w_we,
    input  logic [3:0]  w_addr,
    input  logic [31:0] w_data,
    input  logic        in_valid,
    input  logic [7:0]  in_pixel,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  conv_pixel_in,
    output logic [7:0]  conv_w1,
    output logic [7:0]  conv_w2,
    output logic [7:0]  conv_w3,
    output logic [7:0]  conv_w4,
    output logic [7:0]  conv_w5,
    output logic [7:0]  conv_w6,
    output logic [7:0]  conv_w7,
    output logic [7:0]  conv_w8,
    output logic [7:0]  conv_w9,
    output logic [31:0] conv_bias,
    output logic [7:0]  conv_width,
    output logic        conv_paddingl,
    output logic        conv_paddingr,
    output logic        conv_relu,
    output logic [1:0]  conv_operation,
    input  logic [19:0] conv_pixel_out,
    output logic        out_valid,
    output logic [19:0] out_data,
    output logic [7:0]  out_row,
    output logic [7:0]  out_col
);

    state_t                      state, state_nx;
    frame_cfg_t                  cfg_in, cfg_q;
    out_tag_t                    s1_q;
    logic [DIM_W-1:0]            row_q, col_q;
    logic [DIM_W-1:0]            tag_row, tag_col;
    logic                        cfg_bad, accept, last_pix, res_valid, pad_l, pad_r;
    logic [N_TAPS*COEF_W-1:0]    bank_w;

    assign cfg_in   = '{width: cfg_width, height: cfg_height, op: cfg_op, relu: cfg_relu};
    assign cfg_bad  = cfg_invalid(cfg_in, DIM_W'(MAX_WIDTH), DIM_W'(MAX_HEIGHT));
    assign accept   = (state == ST_STREAM) && in_valid;
    assign last_pix = (col_q == cfg_q.width - 8'd1) && (row_q == cfg_q.height - 8'd1);

    conv3x3_weight_bank u_bank (
        .clk     (clk),
        .rst     (rst),
        .we      (w_we && (state == ST_IDLE)),
        .addr    (w_addr),
        .data    (w_data),
        .weights (bank_w),
        .bias    (conv_bias)
    );

    assign conv_w1 = bank_w[0*COEF_W +: COEF_W];
    assign conv_w2 = bank_w[1*COEF_W +: COEF_W];
    assign conv_w3 = bank_w[2*COEF_W +: COEF_W];
    assign conv_w4 = bank_w[3*COEF_W +: COEF_W];
    assign conv_w5 = bank_w[4*COEF_W +: COEF_W];
    assign conv_w6 = bank_w[5*COEF_W +: COEF_W];
    assign conv_w7 = bank_w[6*COEF_W +: COEF_W];
    assign conv_w8 = bank_w[7*COEF_W +: COEF_W];
    assign conv_w9 = bank_w[8*COEF_W +: COEF_W];

    assign conv_width     = cfg_q.width;
    assign conv_operation = cfg_q.op;
    assign conv_relu      = cfg_q.relu;

    // The collector shifts every clock, so a missing pixel is fed as zero.
    assign conv_pixel_in = accept ? in_pixel : '0;
    assign conv_paddingl = (state == ST_STREAM) && pad_l;
    assign conv_paddingr = (state == ST_STREAM) && pad_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (start) state_nx = cfg_bad ? ST_DONE : ST_STREAM;
            ST_STREAM: if (!in_valid || last_pix) state_nx = ST_DONE;
            ST_DONE:   state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // Result geometry for the pixel being presented; window centre is one row
    // and one column behind it, wrapping to the previous row's last column.
    always_comb begin
        res_valid = 1'b0;
        tag_row   = '0;
        tag_col   = '0;
        pad_l     = 1'b0;
        pad_r     = 1'b0;
        if (cfg_q.op == OP_MAXPOOL2X2) begin
            res_valid = row_q[0] && col_q[0];
            tag_row   = row_q >> 1;
            tag_col   = col_q >> 1;
        end else begin
            res_valid = (row_q >= 8'd2) && ((col_q != '0) || (row_q >= 8'd3));
            pad_l     = (col_q == 8'd1);
            pad_r     = (col_q == '0);
            if (col_q != '0) begin
                tag_row = row_q - 8'd2;
                tag_col = col_q - 8'd1;
            end else begin
                tag_row = row_q - 8'd3;
                tag_col = cfg_q.width - 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_q     <= '0;
            row_q     <= '0;
            col_q     <= '0;
            s1_q      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            out_col   <= '0;
        end else begin
            busy      <= (state_nx != ST_IDLE);
            done      <= (state == ST_DONE);
            s1_q      <= '{valid: accept && res_valid, row: tag_row, col: tag_col};
            out_valid <= s1_q.valid;
            if (s1_q.valid) begin
                out_data <= conv_pixel_out;
                out_row  <= s1_q.row;
                out_col  <= s1_q.col;
            end
            if ((state == ST_IDLE) && start) begin
                cfg_q <= cfg_in;
                err   <= cfg_bad;
                row_q <= '0;
                col_q <= '0;
            end
            if (state == ST_STREAM) begin
                if (!in_valid) begin
                    err <= 1'b1;
                end else if (col_q == cfg_q.width - 8'd1) begin
                    col_q <= '0;
                    row_q <= row_q + 8'd1;
                end else begin
                    col_q <= col_q + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv3x3_sequencer.sv
// Directed bench for conv3x3_sequencer with a behavioural convolutor3x3 model
// standing in for the datapath; results are compared against hand-computed tables.
module tb_conv3x3_sequencer;
    import conv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, cfg_relu, w_we, in_valid;
    logic [7:0]  cfg_width, cfg_height, in_pixel;
    logic [1:0]  cfg_op;
    logic [3:0]  w_addr;
    logic [31:0] w_data;
    logic        busy, done, err;
    logic [7:0]  conv_pixel_in, conv_width;
    logic [7:0]  conv_w1, conv_w2, conv_w3, conv_w4, conv_w5, conv_w6, conv_w7, conv_w8, conv_w9;
    logic [31:0] conv_bias;
    logic        conv_paddingl, conv_paddingr, conv_relu;
    logic [1:0]  conv_operation;
    logic [19:0] conv_pixel_out;
    logic        out_valid;
    logic [19:0] out_data;
    logic [7:0]  out_row, out_col;

    always #5 clk = ~clk;

    conv3x3_sequencer dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_op(cfg_op), .cfg_relu(cfg_relu),
        .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .in_valid(in_valid), .in_pixel(in_pixel),
        .busy(busy), .done(done), .err(err),
        .conv_pixel_in(conv_pixel_in),
        .conv_w1(conv_w1), .conv_w2(conv_w2), .conv_w3(conv_w3),
        .conv_w4(conv_w4), .conv_w5(conv_w5), .conv_w6(conv_w6),
        .conv_w7(conv_w7), .conv_w8(conv_w8), .conv_w9(conv_w9),
        .conv_bias(conv_bias), .conv_width(conv_width),
        .conv_paddingl(conv_paddingl), .conv_paddingr(conv_paddingr),
        .conv_relu(conv_relu), .conv_operation(conv_operation),
        .conv_pixel_out(conv_pixel_out),
        .out_valid(out_valid), .out_data(out_data), .out_row(out_row), .out_col(out_col)
    );

    // Datapath model: shift register of recent pixels, registered result.
    logic signed [7:0] dbuf [0:259];
    logic [19:0]       dp_out;
    assign conv_pixel_out = dp_out;

    function automatic int px(input int o);
        if (o == 0) return int'($signed(conv_pixel_in));
        return int'(dbuf[o-1]);
    endfunction

    function automatic int coef(input int n);
        case (n)
            0: return int'($signed(conv_w1));
            1: return int'($signed(conv_w2));
            2: return int'($signed(conv_w3));
            3: return int'($signed(conv_w4));
            4: return int'($signed(conv_w5));
            5: return int'($signed(conv_w6));
            6: return int'($signed(conv_w7));
            7: return int'($signed(conv_w8));
            default: return int'($signed(conv_w9));
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_out <= '0;
            for (int k = 0; k < 260; k++) dbuf[k] <= '0;
        end else begin
            int acc, x, wd, m;
            wd = int'(conv_width);
            if (conv_operation == OP_MAXPOOL2X2) begin
                acc = px(0);
                m = px(1);      if (m > acc) acc = m;
                m = px(wd);     if (m > acc) acc = m;
                m = px(wd + 1); if (m > acc) acc = m;
            end else begin
                acc = int'($signed(conv_bias));
                for (int i = 0; i < 3; i++) begin
                    for (int j = 0; j < 3; j++) begin
                        x = px((2 - i) * wd + (2 - j));
                        if ((conv_paddingl && j == 0) || (conv_paddingr && j == 2)) x = 0;
                        acc = acc + coef(i * 3 + j) * x;
                    end
                end
            end
            if (conv_relu && acc < 0) acc = 0;
            dp_out  <= 20'(acc);
            dbuf[0] <= $signed(conv_pixel_in);
            for (int k = 1; k < 260; k++) dbuf[k] <= dbuf[k-1];
        end
    end

    // Output collector.
    int          cyc = 0;
    int          done_cnt = 0, done_cyc = 0, last_v_cyc = 0;
    logic        done_busy = 1'b0, done_err = 1'b0;
    logic [35:0] res_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid) begin
            res_q.push_back({out_row, out_col, out_data});
            last_v_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc  = cyc;
            done_busy = busy;
            done_err  = err;
        end
    end

    int          n_checks = 0;
    int          n_fail = 0;
    logic [35:0] exp_q [$];
    logic [7:0]  pix [0:15];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [35:0] mk(input int r, input int c, input int d);
        return {8'(r), 8'(c), 20'(d)};
    endfunction

    // Expected 4x4 conv result table: columns 0 and 3 see one padded column.
    task automatic fill_conv(input int edge_v, input int mid_v);
        exp_q.delete();
        exp_q.push_back(mk(0, 0, edge_v));
        exp_q.push_back(mk(0, 1, mid_v));
        exp_q.push_back(mk(0, 2, mid_v));
        exp_q.push_back(mk(0, 3, edge_v));
        exp_q.push_back(mk(1, 0, edge_v));
        exp_q.push_back(mk(1, 1, mid_v));
        exp_q.push_back(mk(1, 2, mid_v));
    endtask

    task automatic cmp_results(input string tag, input int base);
        check_eq({tag, "_count"}, 64'(res_q.size() - base), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && base + i < res_q.size(); i++)
            check_eq($sformatf("%s_res%0d", tag, i), 64'(res_q[base+i]), 64'(exp_q[i]));
    endtask

    task automatic write_w(input logic [3:0] a, input logic [31:0] d);
        w_we = 1'b1; w_addr = a; w_data = d;
        @(negedge clk);
        w_we = 1'b0;
    endtask

    task automatic load_weights(input logic [31:0] w, input logic [31:0] b);
        for (int a = 0; a < 9; a++) write_w(4'(a), w);
        write_w(W_ADDR_BIAS, b);
    endtask

    task automatic run_frame(input logic [1:0] op, input logic relu, input logic [7:0] w,
                             input logic [7:0] h, input int n_pix, input int drop_at,
                             output int s_cyc, output int d0, output int r0);
        d0 = done_cnt;
        r0 = res_q.size();
        cfg_op = op; cfg_relu = relu; cfg_width = w; cfg_height = h; start = 1'b1;
        s_cyc = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < n_pix; k++) begin
            if (k == drop_at) begin
                in_valid = 1'b0; in_pixel = '0;
                @(negedge clk);
                break;
            end
            in_valid = 1'b1; in_pixel = pix[k];
            @(negedge clk);
        end
        in_valid = 1'b0; in_pixel = '0;
        for (int t = 0; t < 40 && done_cnt == d0; t++) @(negedge clk);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int s, d0, r0;
        rst = 1'b1; start = 1'b0; cfg_width = '0; cfg_height = '0; cfg_op = '0; cfg_relu = 1'b0;
        w_we = 1'b0; w_addr = '0; w_data = '0; in_valid = 1'b0; in_pixel = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 64'(busy), 64'(0));
        check_eq("rst_done", 64'(done), 64'(0));
        check_eq("rst_err", 64'(err), 64'(0));
        check_eq("rst_out_valid", 64'(out_valid), 64'(0));
        check_eq("rst_out_data", 64'(out_data), 64'(0));
        check_eq("rst_conv_w5", 64'(conv_w5), 64'(0));
        check_eq("rst_conv_width", 64'(conv_width), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        load_weights(32'd1, 32'd0);
        check_eq("wload_w1", 64'(conv_w1), 64'h01);
        check_eq("wload_w9", 64'(conv_w9), 64'h01);
        check_eq("wload_bias", 64'(conv_bias), 64'h0);

        // Conv 4x4, all-ones pixels and weights.
        for (int k = 0; k < 16; k++) pix[k] = 8'd1;
        run_frame(OP_CONV3X3, 1'b0, 8'd4, 8'd4, 16, -1, s, d0, r0);
        fill_conv(6, 9);
        cmp_results("conv_ones", r0);
        check_eq("conv_ones_done_cnt", 64'(done_cnt - d0), 64'(1));
        check_eq("conv_ones_done_lat", 64'(done_cyc - s), 64'(17));
        check_eq("conv_ones_done_with_last", 64'(last_v_cyc), 64'(done_cyc));
        check_eq("conv_ones_err", 64'(done_err), 64'(0));
        check_eq("conv_ones_busy_at_done", 64'(done_busy), 64'(0));

        // Negative weights with and without ReLU.
        load_weights(32'hFFFF_FFFF, 32'd0);
        run_frame(OP_CONV3X3, 1'b1, 8'd4, 8'd4, 16, -1, s, d0, r0);
        fill_conv(0, 0);
        cmp_results("conv_neg_relu", r0);
        run_frame(OP_CONV3X3, 1'b0, 8'd4, 8'd4, 16, -1, s, d0, r0);
        fill_conv(-6, -9);
        cmp_results("conv_neg", r0);

        // in_valid dropped at pixel 6 aborts the frame.
        run_frame(OP_CONV3X3, 1'b0, 8'd4, 8'd4, 16, 6, s, d0, r0);
        exp_q.delete();
        cmp_results("drop", r0);
        check_eq("drop_done_cnt", 64'(done_cnt - d0), 64'(1));
        check_eq("drop_err_at_done", 64'(done_err), 64'(1));
        check_eq("drop_busy_at_done", 64'(done_busy), 64'(0));
        check_eq("drop_err_held", 64'(err), 64'(1));

        // Maxpool 4x4 over pixels 0..15.
        for (int k = 0; k < 16; k++) pix[k] = 8'(k);
        run_frame(OP_MAXPOOL2X2, 1'b0, 8'd4, 8'd4, 16, -1, s, d0, r0);
        exp_q.delete();
        exp_q.push_back(mk(0, 0, 5));
        exp_q.push_back(mk(0, 1, 7));
        exp_q.push_back(mk(1, 0, 13));
        exp_q.push_back(mk(1, 1, 15));
        cmp_results("maxpool", r0);
        check_eq("maxpool_err_cleared", 64'(done_err), 64'(0));
        check_eq("maxpool_done_with_last", 64'(last_v_cyc), 64'(done_cyc));

        // Rejected configurations.
        run_frame(OP_TRANSCONV, 1'b0, 8'd4, 8'd4, 0, -1, s, d0, r0);
        exp_q.delete();
        cmp_results("transconv", r0);
        check_eq("transconv_err", 64'(done_err), 64'(1));
        check_eq("transconv_done_lat", 64'(done_cyc - s), 64'(1));
        run_frame(OP_CONV3X3, 1'b0, 8'd2, 8'd4, 0, -1, s, d0, r0);
        cmp_results("conv_w2", r0);
        check_eq("conv_w2_err", 64'(done_err), 64'(1));
        check_eq("conv_w2_done_lat", 64'(done_cyc - s), 64'(1));

        // Reset in the middle of a streaming frame.
        write_w(W_ADDR_BIAS, 32'd5);
        for (int k = 0; k < 16; k++) pix[k] = 8'd1;
        cfg_op = OP_CONV3X3; cfg_relu = 1'b0; cfg_width = 8'd4; cfg_height = 8'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            in_valid = 1'b1; in_pixel = pix[k];
            @(negedge clk);
        end
        check_eq("midrst_busy_before", 64'(busy), 64'(1));
        rst = 1'b1; in_valid = 1'b0; in_pixel = '0;
        #1;
        check_eq("midrst_busy", 64'(busy), 64'(0));
        check_eq("midrst_out_valid", 64'(out_valid), 64'(0));
        check_eq("midrst_w5", 64'(conv_w5), 64'(0));
        check_eq("midrst_bias", 64'(conv_bias), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("midrst_idle_busy", 64'(busy), 64'(0));
        check_eq("midrst_idle_out_valid", 64'(out_valid), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
